// File: rtl/mult_pkg.sv
// Shared types and helpers for the mult_sel8_seq multiplier.
// Holds the FSM state enum and the ceil-div-3 helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRECOMP,
        ACCUM,
        DONE
    } state_t;

    function automatic int ceilDiv3(input int w);
        return (w + 2) / 3;
    endfunction

endpackage

// File: rtl/mult_sel8_seq_mux8.sv
// Purely combinational 8-way selector.
// Picks one of eight W-bit multiples by a 3-bit select.
module mux8_param #(
    parameter int W = 35
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    input  logic [W-1:0] in4,
    input  logic [W-1:0] in5,
    input  logic [W-1:0] in6,
    input  logic [W-1:0] in7,
    input  logic [2:0]   sel,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        unique case (sel)
            3'd0: y = in0;
            3'd1: y = in1;
            3'd2: y = in2;
            3'd3: y = in3;
            3'd4: y = in4;
            3'd5: y = in5;
            3'd6: y = in6;
            3'd7: y = in7;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mult_sel8_seq.sv
// Sequential radix-8 multiplier: precompute 0..7*A, then add one group per cycle.
// Define MULT_EARLY_TERM_EN to stop once the remaining multiplier groups are zero.
module mult_sel8_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product
);

    localparam int NGRP = ceilDiv3(WIDTH);
    localparam int BW   = 3 * NGRP;
    localparam int MW   = WIDTH + 3;
    localparam int PW   = 2 * WIDTH;
    localparam int IW   = $clog2(NGRP + 1);

    state_t state;
    state_t nextState;

    logic [WIDTH-1:0] aCap;
    logic [BW-1:0]    bSh;
    logic [MW-1:0]    mult [8];
    logic [PW-1:0]    acc;
    logic [IW-1:0]    idx;

    logic [MW-1:0] mSel;
    logic [7:0]    shAmt;
    logic [PW-1:0] addend;
    logic [PW-1:0] accNext;
    logic          lastGrp;
    logic          startOk;

    assign startOk = Start && (state == IDLE || state == DONE);
    assign Busy    = (state == PRECOMP) || (state == ACCUM);
    assign Done    = (state == DONE);

    mux8_param #(.W(MW)) uMux (
        .in0 (mult[0]),
        .in1 (mult[1]),
        .in2 (mult[2]),
        .in3 (mult[3]),
        .in4 (mult[4]),
        .in5 (mult[5]),
        .in6 (mult[6]),
        .in7 (mult[7]),
        .sel (bSh[2:0]),
        .y   (mSel)
    );

    // bSh is shifted down each group, so bits [2:0] are always the current one
    assign shAmt   = 8'(idx) * 8'd3;
    assign addend  = PW'(mSel) << shAmt;
    assign accNext = acc + addend;

`ifdef MULT_EARLY_TERM_EN
    assign lastGrp = (idx == IW'(NGRP - 1)) || (bSh[BW-1:3] == '0);
`else
    assign lastGrp = (idx == IW'(NGRP - 1));
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    nextState = Start ? PRECOMP : IDLE;
            PRECOMP: nextState = ACCUM;
            ACCUM:   nextState = lastGrp ? DONE : ACCUM;
            DONE:    nextState = Start ? PRECOMP : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            aCap    <= '0;
            bSh     <= '0;
            acc     <= '0;
            idx     <= '0;
            Product <= '0;
            for (int k = 0; k < 8; k++) begin
                mult[k] <= '0;
            end
        end else begin
            if (startOk) begin
                aCap <= A;
                bSh  <= BW'(B);
                acc  <= '0;
                idx  <= '0;
            end
            if (state == PRECOMP) begin
                for (int k = 0; k < 8; k++) begin
                    mult[k] <= MW'(aCap) * MW'(k);
                end
            end
            if (state == ACCUM) begin
                acc <= accNext;
                idx <= idx + 1'b1;
                bSh <= bSh >> 3;
                if (lastGrp) begin
                    Product <= accNext;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_sel8_seq.sv
// Self-checking bench for mult_sel8_seq at WIDTH=32 and WIDTH=8.
// Expected products and latencies come from plain arithmetic on the operands.
module tb_mult_sel8_seq;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Busy;
    logic        Done;
    logic [63:0] Product;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;

    int checks = 0;
    int errors = 0;

    mult_sel8_seq #(.WIDTH(32)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .Product (Product)
    );

    mult_sel8_seq #(.WIDTH(8)) dut8 (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (start8),
        .A       (a8),
        .B       (b8),
        .Busy    (busy8),
        .Done    (done8),
        .Product (product8)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle in which Done is expected, counting the Start edge as edge 0
    function automatic int expDone(input logic [63:0] b, input int ngrp);
        int g;
        g = ngrp;
`ifdef MULT_EARLY_TERM_EN
        g = 1;
        for (int i = 0; i < ngrp; i++) begin
            if (((b >> (3 * i)) & 64'd7) != 0) g = i + 1;
        end
`endif
        return g + 2;
    endfunction

    task automatic startOp(input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        A = a;
        B = b;
        tick();
        Start = 1'b0;
    endtask

    // Called in cycle 1; returns in the Done cycle (or after timeout)
    task automatic waitDone(input string name, input logic [63:0] expP,
                            input int expC, input int pulseCyc);
        int doneCyc;
        bit busyBad;
        doneCyc = 0;
        busyBad = 0;
        for (int c = 1; c <= 40 && doneCyc == 0; c++) begin
            if (Done) begin
                doneCyc = c;
                if (Busy) busyBad = 1;
            end else begin
                if (!Busy) busyBad = 1;
                Start = (c == pulseCyc);
                if (c == pulseCyc) begin
                    A = 32'd100;
                    B = 32'd100;
                end
                tick();
                Start = 1'b0;
            end
        end
        chk({name, " doneCyc"}, 64'(doneCyc), 64'(expC));
        chk({name, " product"}, Product, expP);
        chk({name, " busy"}, 64'(busyBad), 64'd0);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b);
        int doneCyc;
        doneCyc = 0;
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        tick();
        start8 = 1'b0;
        for (int c = 1; c <= 30 && doneCyc == 0; c++) begin
            if (done8) doneCyc = c;
            else tick();
        end
        chk("w8 doneCyc", 64'(doneCyc), 64'(expDone(64'(b), 3)));
        chk("w8 product", 64'(product8), 64'(a) * 64'(b));
        tick();
    endtask

    initial begin
        logic [63:0] oldP;
        bit sawDone;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[1] = '{32'd7,          32'd5,          64'd35};
        vecs[2] = '{32'd0,          32'hDEAD_BEEF,  64'd0};
        vecs[3] = '{32'h1234_5678,  32'd0,          64'd0};
        vecs[4] = '{32'd1,          32'd1,          64'd1};
        vecs[5] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF};
        vecs[6] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
        vecs[7] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};

        tick();
        tick();
        chk("reset busy", 64'(Busy), 64'd0);
        chk("reset done", 64'(Done), 64'd0);
        chk("reset product", Product, 64'd0);
        Reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            startOp(vecs[i].a, vecs[i].b);
            waitDone($sformatf("vec%0d", i), vecs[i].prod,
                     expDone(64'(vecs[i].b), 11), 0);
            tick();
            chk($sformatf("vec%0d idle", i), 64'(Done), 64'd0);
        end

        startOp(32'd3, 32'd9);
        waitDone("ignoreStart", 64'd27, expDone(64'd9, 11), 5);
        tick();

        startOp(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int c = 1; c < 6; c++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("midReset busy", 64'(Busy), 64'd0);
        chk("midReset done", 64'(Done), 64'd0);
        chk("midReset product", Product, 64'd0);
        sawDone = 0;
        for (int c = 0; c < 20; c++) begin
            if (Done || Busy) sawDone = 1;
            tick();
        end
        chk("midReset quiet", 64'(sawDone), 64'd0);

        startOp(32'hABCD_0123, 32'h0000_7777);
        oldP = 64'(32'hABCD_0123) * 64'(32'h0000_7777);
        waitDone("b2b first", oldP, expDone(64'h7777, 11), 0);
        startOp(32'd2, 32'd3);
        chk("b2b hold", Product, oldP);
        chk("b2b busy", 64'(Busy), 64'd1);
        waitDone("b2b second", 64'd6, expDone(64'd3, 11), 0);
        tick();

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) rb = 32'($urandom_range(0, 4095));
            startOp(ra, rb);
            waitDone($sformatf("rand%0d", i), 64'(ra) * 64'(rb),
                     expDone(64'(rb), 11), 0);
            tick();
        end

        run8(8'hFF, 8'hFF);
        run8(8'h0F, 8'h03);
        run8(8'h00, 8'hA5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
